// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the MEM-stage load/store unit:
// funct3 encodings, LSU FSM states and store-side lane helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } lsu_state_t;

    // size is funct3[1:0]; 2'b1x (incl. unused encodings) is a word access
    function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(parameter int ADDR_W = 32);

    logic              dmem_req;
    logic              dmem_we;
    logic [3:0]        dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects the addressed byte/half lane of the
// read word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ldata
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        case (funct3)
            F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ldata = {24'b0, lane_b};
            F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ldata = {16'b0, lane_h};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: launches one data-memory access per instruction,
// stalls the pipeline while it is outstanding and formats load results for WB.
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_ALU_out,
    input  logic [31:0]       mem_DataB,
    output logic              stall_req_mem,
    output logic              misalign_exc,
    output logic [31:0]       wb_ldata,
    output logic              wb_ldata_valid,
    mem_lsu_if.master         dmem
);

    lsu_state_t state, state_nx;

    logic              we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        f3_q;

    logic        access, misaligned, accept, finish_ld;
    logic [31:0] ldata_fmt;

    assign access     = mem_valid && (mem_we || mem_re);
    assign misaligned = lsu_misaligned(mem_funct3[1:0], mem_ALU_out[1:0]);
    assign accept     = (state == S_IDLE) && access && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // finish_ld marks the edge that enters DONE with load data in hand
    always_comb begin
        state_nx  = state;
        finish_ld = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nx = S_REQ;
            S_REQ: begin
                if (dmem.dmem_gnt) begin
                    if (we_q) begin
                        state_nx = S_DONE;
                    end else if (dmem.dmem_rvalid) begin
                        state_nx  = S_DONE;
                        finish_ld = 1'b1;
                    end else begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (dmem.dmem_rvalid) begin
                    state_nx  = S_DONE;
                    finish_ld = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign stall_req_mem = accept || (state == S_REQ) || (state == S_RESP);
    assign misalign_exc  = (state == S_IDLE) && access && misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q           <= 1'b0;
            be_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            addr_lo_q      <= '0;
            f3_q           <= '0;
            wb_ldata       <= '0;
            wb_ldata_valid <= 1'b0;
        end else begin
            wb_ldata_valid <= finish_ld;
            if (accept) begin
                we_q      <= mem_we;
                be_q      <= lsu_be(mem_funct3[1:0], mem_ALU_out[1:0]);
                addr_q    <= {mem_ALU_out[ADDR_W-1:2], 2'b00};
                wdata_q   <= lsu_wdata(mem_funct3[1:0], mem_DataB);
                addr_lo_q <= mem_ALU_out[1:0];
                f3_q      <= mem_funct3;
            end
            if (finish_ld) wb_ldata <= ldata_fmt;
        end
    end

    lsu_load_align u_align (
        .rdata   (dmem.dmem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (f3_q),
        .ldata   (ldata_fmt)
    );

    assign dmem.dmem_req   = (state == S_REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs (address, store data, access type) and runs a request/grant/response handshake to data memory. It raises a stall request to the stall controller while an access is outstanding. It presents the formatted load result to the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 32: address width; the data path is fixed at 32 bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  an instruction is present in MEM.
- `mem_we`  in  1  store.
- `mem_re`  in  1  load; ignored when `mem_we`=1.
- `mem_funct3`  in  3  access size/sign (RV32I encoding).
- `mem_ALU_out`  in  ADDR_W  effective byte address.
- `mem_DataB`  in  32  store data.
- `stall_req_mem`  out  1  hold the pipeline at MEM and upstream.
- `misalign_exc`  out  1  misaligned-access flag.
- `wb_ldata`  out  32  formatted load result.
- `wb_ldata_valid`  out  1  one-cycle pulse when `wb_ldata` is updated.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  request is a write.
- `dmem_be`  out  4  byte enables.
- `dmem_addr`  out  ADDR_W  word-aligned address `{addr[ADDR_W-1:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - Accept condition: `mem_valid` and (`mem_we` or `mem_re`) and the address is aligned.
  - On accept: register `dmem_*` and go to REQ.
  - `stall_req_mem` is asserted combinationally in the accept cycle.
- **REQ**
  - `dmem_req`=1; all `dmem_*` outputs are held stable until `dmem_gnt`.
  - Store with `dmem_gnt` → DONE.
  - Load with `dmem_gnt` → RESP, or → DONE if `dmem_rvalid` arrives in the same cycle.
- **RESP** (loads only): wait for `dmem_rvalid`, then capture the formatted data → DONE.
- **DONE**
  - `stall_req_mem`=0, so EX/MEM advances at this edge.
  - `wb_ldata_valid`=1 for loads.
  - Next state is always IDLE; the same instruction is never re-launched.
- `stall_req_mem` = (IDLE and accept) or state ∈ {REQ, RESP}.
- **Misalignment**
  - Misaligned when: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
  - Response: `misalign_exc` is asserted combinationally in IDLE, no request is issued, no stall.
- **Byte enables**: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`.
- **Store data**: SB replicates the byte into all 4 lanes; SH replicates the half into both halves; SW passes through unchanged.
- **Load format**: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes through unchanged.
- **Unused funct3** (011/110/111): treated as a word access.
- `dmem_rvalid` outside RESP/REQ is ignored.
- **Reset**
  - Sets FSM to IDLE; `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `wb_ldata`, `wb_ldata_valid` = 0.
  - Reset mid-access abandons the access; a late `rvalid` is ignored.
- `wb_ldata` holds its value until the next load completes.

## Timing
- Zero-wait memory (`gnt` in the first REQ cycle, `rvalid` one cycle later):
  - Load: accept (cycle 0), REQ (cycle 1), RESP (cycle 2), DONE (cycle 3). Three stall cycles; `wb_ldata` is valid in cycle 3.
  - Store: accept, REQ, DONE. Two stall cycles.
- Each cycle without `gnt` in REQ, or without `rvalid` in RESP, adds one stall cycle.
- `dmem_req` drops in the cycle after `gnt`.
- At most one access is outstanding.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_state_t` enum.
- Sub-module `lsu_load_align`: combinational lane select and sign/zero extension from (`rdata`, `addr[1:0]`, `funct3`).

## Test plan
- LW at 0x100, `rdata`=0xDEADBEEF, zero-wait → `dmem_be`=4'hF, `stall_req_mem` high 3 cycles, `wb_ldata`=0xDEADBEEF with one `wb_ldata_valid` pulse.
- LB at 0x103, `rdata`=0x80xxxxxx → `be`=4'b1000, `wb_ldata`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, `DataB`=0x1234ABCD → `dmem_addr`=0x200, `be`=4'b1100, `wdata`=0xABCDABCD, `gnt` delayed 3 cycles → stall held 5 cycles and `dmem_*` stable throughout.
- LW at 0x101 → `misalign_exc`=1, `dmem_req` never asserted, `stall_req_mem`=0.
- Load with `gnt` and `rvalid` in the same REQ cycle → DONE next cycle, 2 stall cycles total.
- `rst` asserted in RESP, then `rvalid` arrives → outputs zero, FSM in IDLE, no `wb_ldata_valid` pulse.
